countdown_display: RTL

Game-clock countdown with 4-digit seven-segment multiplexing, directly downstream of the clock divider. Consumes the divider's 500 Hz scan clock and 1 Hz clock as levels, edge-detects them in the master clock domain, maintains an MM:SS BCD countdown, and drives common-anode display lines. Flags round expiry to the game FSM.

---
 rtl/countdown_display_pkg.sv | 73 +++++++
 rtl/countdown_display_bcd_to_seg.sv | 34 +++
 rtl/countdown_display.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/countdown_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_display_pkg
// Description : Shared types and constants for the MM:SS countdown display:
//               FSM state encoding, BCD time record, seven-segment patterns
//               and the BCD time decrement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_display_pkg;

    // Width of one BCD digit
    localparam int c_bcd_w = 4;

    // Countdown controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // MM:SS as four BCD digits, most significant first
    typedef struct packed {
        logic [c_bcd_w-1:0] m10;
        logic [c_bcd_w-1:0] m1;
        logic [c_bcd_w-1:0] s10;
        logic [c_bcd_w-1:0] s1;
    } bcd_time_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0     = 7'h40;
    localparam logic [6:0] c_seg_1     = 7'h79;
    localparam logic [6:0] c_seg_2     = 7'h24;
    localparam logic [6:0] c_seg_3     = 7'h30;
    localparam logic [6:0] c_seg_4     = 7'h19;
    localparam logic [6:0] c_seg_5     = 7'h12;
    localparam logic [6:0] c_seg_6     = 7'h02;
    localparam logic [6:0] c_seg_7     = 7'h78;
    localparam logic [6:0] c_seg_8     = 7'h00;
    localparam logic [6:0] c_seg_9     = 7'h10;
    localparam logic [6:0] c_seg_blank = 7'h7F;

    // One-second decrement with BCD borrows: seconds wrap to 59, minutes
    // ones wrap to 9. Callers only invoke this on a non-zero time; the
    // m10 guard keeps 00:00 from wrapping if that ever changes.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
        end else begin
            r.s1 = 4'd9;
            if (t.s10 != 4'd0) begin
                r.s10 = t.s10 - 4'd1;
            end else begin
                r.s10 = 4'd5;
                if (t.m1 != 4'd0) begin
                    r.m1 = t.m1 - 4'd1;
                end else begin
                    r.m1 = 4'd9;
                    if (t.m10 != 4'd0) begin
                        r.m10 = t.m10 - 4'd1;
                    end else begin
                        r = '0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage : countdown_display_pkg
`default_nettype wire

// File: rtl/countdown_display_bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD to active-low seven-segment decoder.
//               Codes 10-15 produce a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import countdown_display_pkg::*;
(
    input  logic [c_bcd_w-1:0] bcd_i,
    output logic [6:0]         seg_o
);

    // Pattern lookup; anything outside 0-9 is blanked
    always_comb begin
        seg_o = c_seg_blank;
        case (bcd_i)
            4'd0:    seg_o = c_seg_0;
            4'd1:    seg_o = c_seg_1;
            4'd2:    seg_o = c_seg_2;
            4'd3:    seg_o = c_seg_3;
            4'd4:    seg_o = c_seg_4;
            4'd5:    seg_o = c_seg_5;
            4'd6:    seg_o = c_seg_6;
            4'd7:    seg_o = c_seg_7;
            4'd8:    seg_o = c_seg_8;
            4'd9:    seg_o = c_seg_9;
            default: seg_o = c_seg_blank;
        endcase
    end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/countdown_display.sv
`default_nettype none
// ============================================================================
// Module      : countdown_display
// Description : MM:SS game-clock countdown with 4-digit multiplexed
//               common-anode seven-segment output. Edge-detects the divider's
//               scan and 1 Hz levels in the master clock domain, runs an
//               IDLE/RUN/PAUSE/DONE controller and flags expiry.
//               Optional build macro COUNTDOWN_BLINK_EN: in DONE the anodes
//               are blanked while sec_clk_in is low (1 Hz blink).
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_display
    import countdown_display_pkg::*;
#(
    parameter int START_MIN = 2,
    parameter int START_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_clk_in,
    input  logic       sec_clk_in,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       time_up,
    output logic       running
);

    // Reload value as BCD digits
    localparam bcd_time_t c_start_time = bcd_time_t'({
        4'(START_MIN / 10), 4'(START_MIN % 10),
        4'(START_SEC / 10), 4'(START_SEC % 10)
    });

    // Index of the minutes-ones digit, which carries the MM.SS separator
    localparam logic [1:0] c_dp_digit = 2'd2;

    logic        seg_prev_q;
    logic        sec_prev_q;
    logic        w_scan_tick;
    logic        w_sec_tick;

    state_e      state_q;
    state_e      state_d;
    bcd_time_t   cnt_q;
    bcd_time_t   cnt_d;
    logic        time_up_q;
    logic        running_q;

    logic [1:0]          idx_q;
    logic [c_bcd_w-1:0]  w_digit;
    logic [6:0]          w_seg_pat;
    logic [3:0]          an_q;
    logic [6:0]          seg_q;
    logic                dp_q;
    logic                w_blank;

    // Previous level of both divider outputs for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_prev_q <= 1'b0;
            sec_prev_q <= 1'b0;
        end else begin
            seg_prev_q <= seg_clk_in;
            sec_prev_q <= sec_clk_in;
        end
    end

    // Levels come from the same clock domain, so no synchronizer is needed
    assign w_scan_tick = seg_clk_in & ~seg_prev_q;
    assign w_sec_tick  = sec_clk_in & ~sec_prev_q;

    // Controller next state and counter: load beats pause beats start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_IDLE;
            cnt_d   = c_start_time;
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && w_sec_tick) begin
            // Expiry is taken on the tick after the counter reaches 00:00
            if (cnt_q == '0) begin
                state_d = ST_DONE;
            end else begin
                cnt_d = bcd_dec(cnt_q);
            end
        end
    end

    // Controller state, counter and registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= c_start_time;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            time_up_q <= (state_d == ST_DONE);
            running_q <= (state_d == ST_RUN);
        end
    end

    // Select the digit addressed by the scan index, seconds ones first
    always_comb begin
        w_digit = cnt_q.s1;
        unique case (idx_q)
            2'd0: w_digit = cnt_q.s1;
            2'd1: w_digit = cnt_q.s10;
            2'd2: w_digit = cnt_q.m1;
            2'd3: w_digit = cnt_q.m10;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (w_digit),
        .seg_o (w_seg_pat)
    );

    // On each scan tick latch the current digit onto the display and advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= c_seg_blank;
            dp_q  <= 1'b1;
        end else if (w_scan_tick) begin
            idx_q <= idx_q + 2'd1;
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= w_seg_pat;
            dp_q  <= (idx_q != c_dp_digit);
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    logic blank_q;

    // Blank the anodes during the low half of the 1 Hz clock once expired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= (state_q == ST_DONE) && !sec_clk_in;
        end
    end

    assign w_blank = blank_q;
`else
    assign w_blank = 1'b0;
`endif

    assign an      = an_q | {4{w_blank}};
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign time_up = time_up_q;
    assign running = running_q;

endmodule : countdown_display
`default_nettype wire
